noise_channel: RTL and testbench

Parametrised APU noise voice: pseudo-random LFSR clocked by a period-table timer, with envelope generator, length counter and CPU register write port. Sits in the APU beside the pulse/triangle voices, fed by the frame sequencer (quarter/half-frame strobes) and the CPU register decoder. Its 4-bit `dac` goes to the mixer. Replaces the earlier free-running noise shifter with a correctly timed, resettable, region-selectable implementation.

---
 rtl/apu_pkg.sv | 37 +++
 rtl/apu_envelope.sv | 51 +++++
 rtl/noise_channel.sv | 105 ++++++++++
 tb/tb_noise_channel.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// Shared APU package: length-counter load table, NTSC/PAL noise period
// tables, register address constants and a period lookup helper.
// Used by the noise channel and reusable by the other voices.
package apu_pkg;

  // Register offsets within a voice's four-byte window.
  localparam logic [1:0] ADDR_VOL    = 2'd0;
  localparam logic [1:0] ADDR_UNUSED = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_LENGTH = 2'd3;

  localparam int REGION_NTSC = 0;
  localparam int REGION_PAL  = 1;

  localparam logic [7:0] LEN_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

  localparam logic [11:0] NTSC_PERIOD [16] = '{
    12'd4,   12'd8,   12'd16,  12'd32,  12'd64,   12'd96,   12'd128,  12'd160,
    12'd202, 12'd254, 12'd380, 12'd508, 12'd762,  12'd1016, 12'd2034, 12'd4068
  };

  localparam logic [11:0] PAL_PERIOD [16] = '{
    12'd4,   12'd8,   12'd14,  12'd30,  12'd60,   12'd88,   12'd118,  12'd148,
    12'd188, 12'd236, 12'd354, 12'd472, 12'd708,  12'd944,  12'd1890, 12'd3778
  };

  // Timer period in APU timer ticks for the selected region.
  function automatic logic [11:0] period_of(input int region, input logic [3:0] idx);
    return (region == REGION_PAL) ? PAL_PERIOD[idx] : NTSC_PERIOD[idx];
  endfunction

endpackage

// File: rtl/apu_envelope.sv
// APU envelope generator: start flag, divider and 4-bit decay level,
// clocked by the quarter-frame strobe. Shared by pulse and noise voices.
//   clk, rst_n  : clock, asynchronous active-low reset
//   qframe      : quarter-frame strobe
//   start_set   : request an envelope restart on the next qframe
//   loop        : reload decay to 15 after it reaches 0
//   n           : divider reload value (also the constant volume)
//   decay       : current decay level
module apu_envelope
  import apu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       qframe,
  input  logic       start_set,
  input  logic       loop,
  input  logic [3:0] n,
  output logic [3:0] decay
);

  logic       start;
  logic [3:0] div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start <= 1'b0;
      div   <= 4'd0;
      decay <= 4'd0;
    end else begin
      if (qframe) begin
        if (start) begin
          start <= 1'b0;
          decay <= 4'd15;
          div   <= n;
        end else if (div == 4'd0) begin
          div <= n;
          if (decay != 4'd0)
            decay <= decay - 4'd1;
          else if (loop)
            decay <= 4'd15;
        end else begin
          div <= div - 4'd1;
        end
      end
      // A restart request arriving with a qframe survives to the next qframe.
      if (start_set)
        start <= 1'b1;
    end
  end

endmodule

// File: rtl/noise_channel.sv
// APU noise voice: LFSR stepped by a period-table timer, envelope,
// length counter and CPU register write port.
//   clk, rst_n  : clock, asynchronous active-low reset
//   timer_ce    : APU timer tick
//   qframe      : quarter-frame strobe (envelope)
//   hframe      : half-frame strobe (length counter)
//   len_en      : channel enable; low clears and blocks the length counter
//   wr_en, wr_addr, wr_data : CPU register write port
//   dac         : 4-bit output level to the mixer
//   len_active  : length counter nonzero
module noise_channel
  import apu_pkg::*;
#(
  parameter int LFSR_W    = 15,
  parameter int TAP_LONG  = 1,
  parameter int TAP_SHORT = 6,
  parameter int REGION    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       timer_ce,
  input  logic       qframe,
  input  logic       hframe,
  input  logic       len_en,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [3:0] dac,
  output logic       len_active
);

  logic [5:0]        r0;      // {halt/loop, const, n[3:0]}
  logic              mode;
  logic [3:0]        pidx;
  logic [11:0]       timer;
  logic [LFSR_W-1:0] lfsr;
  logic [7:0]        length;
  logic [3:0]        decay;
  logic              fb;
  logic              wr_len;
  logic              load_len;

  assign wr_len   = wr_en && (wr_addr == ADDR_LENGTH);
  assign load_len = wr_len && len_en;

  always_comb begin
    fb = lfsr[0] ^ (mode ? lfsr[TAP_SHORT] : lfsr[TAP_LONG]);
  end

  apu_envelope u_env (
    .clk       (clk),
    .rst_n     (rst_n),
    .qframe    (qframe),
    .start_set (load_len),
    .loop      (r0[5]),
    .n         (r0[3:0]),
    .decay     (decay)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0     <= 6'd0;
      mode   <= 1'b0;
      pidx   <= 4'd0;
      timer  <= 12'd0;
      lfsr   <= LFSR_W'(1);
      length <= 8'd0;
      dac    <= 4'd0;
    end else begin
      if (wr_en) begin
        case (wr_addr)
          ADDR_VOL:    r0 <= wr_data[5:0];
          ADDR_PERIOD: begin
            mode <= wr_data[7];
            pidx <= wr_data[3:0];
          end
          default: ;
        endcase
      end

      // Period writes only affect the next reload; the running count is kept.
      if (timer_ce) begin
        if (timer == 12'd0) begin
          timer <= period_of(REGION, pidx) - 12'd1;
          lfsr  <= {fb, lfsr[LFSR_W-1:1]};
        end else begin
          timer <= timer - 12'd1;
        end
      end

      // A length load beats a same-cycle half-frame decrement.
      if (!len_en)
        length <= 8'd0;
      else if (load_len)
        length <= LEN_TABLE[wr_data[7:3]];
      else if (hframe && (length != 8'd0) && !r0[5])
        length <= length - 8'd1;

      dac <= (lfsr[0] || (length == 8'd0)) ? 4'd0 : (r0[4] ? r0[3:0] : decay);
    end
  end

  assign len_active = (length != 8'd0);

endmodule

// File: tb/tb_noise_channel.sv
module tb_noise_channel;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       timer_ce = 1'b0;
  logic       qframe = 1'b0;
  logic       hframe = 1'b0;
  logic       len_en = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [7:0] wr_data = 8'd0;
  logic [3:0] dac;
  logic       len_active;

  int vectors = 0;
  int miscompares = 0;

  int ntsc_period [16] = '{4, 8, 16, 32, 64, 96, 128, 160,
                           202, 254, 380, 508, 762, 1016, 2034, 4068};

  // Envelope reference state
  logic       m_start = 1'b0;
  logic [3:0] m_div = 4'd0;
  logic [3:0] m_decay = 4'd0;

  noise_channel dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .timer_ce   (timer_ce),
    .qframe     (qframe),
    .hframe     (hframe),
    .len_en     (len_en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .dac        (dac),
    .len_active (len_active)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick;
    wr_en = 1'b0;
  endtask

  task automatic env_model(input logic qf, input logic ss, input logic [3:0] n, input logic lp);
    if (qf) begin
      if (m_start) begin
        m_start = 1'b0; m_decay = 4'd15; m_div = n;
      end else if (m_div == 4'd0) begin
        m_div = n;
        if (m_decay != 4'd0) m_decay = m_decay - 4'd1;
        else if (lp) m_decay = 4'd15;
      end else begin
        m_div = m_div - 4'd1;
      end
    end
    if (ss) m_start = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    vectors++; if (dac !== 4'd0) begin miscompares++; $display("FAIL reset_dac got %0d want 0", dac); end
    vectors++; if (len_active !== 1'b0) begin miscompares++; $display("FAIL reset_len_active got %0b want 0", len_active); end
    vectors++; if (dut.lfsr !== 15'h0001) begin miscompares++; $display("FAIL reset_lfsr got %h want 0001", dut.lfsr); end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_const_volume;
    len_en = 1'b1;
    tick;
    write_reg(2'd0, 8'h3F);
    write_reg(2'd2, 8'h00);
    write_reg(2'd3, 8'h08);
    vectors++; if (dut.length !== 8'd254) begin miscompares++; $display("FAIL cv_length got %0d want 254", dut.length); end
    vectors++; if (len_active !== 1'b1) begin miscompares++; $display("FAIL cv_len_active got %0b want 1", len_active); end
    timer_ce = 1'b1;
    tick;
    timer_ce = 1'b0;
    vectors++; if (dut.lfsr !== 15'h4000) begin miscompares++; $display("FAIL cv_first_step got %h want 4000", dut.lfsr); end
    tick;
    vectors++; if (dac !== 4'd15) begin miscompares++; $display("FAIL cv_dac got %0d want 15", dac); end
  endtask

  // Continues from test_const_volume: lfsr=0x4000, timer=3, long mode, pidx 0.
  task automatic test_lfsr_scoreboard;
    logic [14:0] m_lfsr;
    logic [11:0] m_timer;
    logic        m_mode;
    logic [3:0]  m_pidx;
    logic        fb;
    logic [3:0]  expd;
    logic [3:0]  exp_q [$];
    logic        ce;
    logic        wr;
    logic [7:0]  wd;
    int          bad;
    m_lfsr = 15'h4000; m_timer = 12'd3; m_mode = 1'b0; m_pidx = 4'd0;
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      ce = ($urandom_range(0, 3) != 0);
      wr = 1'b0; wd = 8'h00;
      if (i == 1000) begin wr = 1'b1; wd = 8'h80; end
      if (i == 2000) begin wr = 1'b1; wd = 8'h01; end
      timer_ce = ce; wr_en = wr; wr_addr = 2'd2; wr_data = wd;
      tick;
      timer_ce = 1'b0; wr_en = 1'b0;
      if (exp_q.size() > 0) begin
        expd = exp_q.pop_front();
        vectors++;
        if (dac !== expd) begin
          miscompares++;
          if (bad < 10) $display("FAIL sb_dac cycle %0d got %0d want %0d", i, dac, expd);
          bad++;
        end
      end
      if (ce) begin
        if (m_timer == 12'd0) begin
          m_timer = 12'(ntsc_period[m_pidx] - 1);
          fb = m_lfsr[0] ^ (m_mode ? m_lfsr[6] : m_lfsr[1]);
          m_lfsr = {fb, m_lfsr[14:1]};
        end else begin
          m_timer = m_timer - 12'd1;
        end
      end
      if (wr) begin m_mode = wd[7]; m_pidx = wd[3:0]; end
      exp_q.push_back(m_lfsr[0] ? 4'd0 : 4'd15);
      vectors++;
      if (dut.lfsr !== m_lfsr || dut.lfsr == 15'h0) begin
        miscompares++;
        if (bad < 10) $display("FAIL sb_lfsr cycle %0d got %h want %h", i, dut.lfsr, m_lfsr);
        bad++;
      end
    end
  endtask

  task automatic test_length;
    write_reg(2'd0, 8'h1F);
    write_reg(2'd3, 8'h00);
    vectors++; if (dut.length !== 8'd10) begin miscompares++; $display("FAIL len_load got %0d want 10", dut.length); end
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        vectors++; if (len_active !== 1'b1) begin miscompares++; $display("FAIL len_before_last got %0b want 1", len_active); end
      end
      hframe = 1'b1;
      tick;
      hframe = 1'b0;
    end
    vectors++; if (len_active !== 1'b0) begin miscompares++; $display("FAIL len_expired got %0b want 0", len_active); end
    tick;
    vectors++; if (dac !== 4'd0) begin miscompares++; $display("FAIL len_dac_muted got %0d want 0", dac); end
    // Halted counter holds
    write_reg(2'd0, 8'h30);
    write_reg(2'd3, 8'h00);
    for (int i = 0; i < 20; i++) begin
      hframe = 1'b1;
      tick;
      hframe = 1'b0;
    end
    vectors++; if (dut.length !== 8'd10) begin miscompares++; $display("FAIL len_halt got %0d want 10", dut.length); end
    // Load and hframe in the same cycle: the load wins
    write_reg(2'd0, 8'h10);
    hframe = 1'b1; wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h08;
    tick;
    hframe = 1'b0; wr_en = 1'b0;
    vectors++; if (dut.length !== 8'd254) begin miscompares++; $display("FAIL len_write_wins got %0d want 254", dut.length); end
  endtask

  task automatic test_envelope;
    // No qframe has occurred since reset; earlier loads only set start.
    m_start = 1'b1; m_div = 4'd0; m_decay = 4'd0;
    write_reg(2'd0, 8'h02);
    write_reg(2'd3, 8'h00);
    for (int k = 1; k <= 58; k++) begin
      if (k == 53) write_reg(2'd0, 8'h22);
      qframe = 1'b1;
      tick;
      qframe = 1'b0;
      env_model(1'b1, 1'b0, 4'd2, (k >= 53));
      vectors++;
      if (dut.u_env.decay !== m_decay) begin
        miscompares++; $display("FAIL env_decay q%0d got %0d want %0d", k, dut.u_env.decay, m_decay);
      end
      if (k == 1) begin
        vectors++; if (dut.u_env.decay !== 4'd15) begin miscompares++; $display("FAIL env_start got %0d want 15", dut.u_env.decay); end
      end
      if (k == 45) begin
        vectors++; if (dut.u_env.decay !== 4'd1) begin miscompares++; $display("FAIL env_q45 got %0d want 1", dut.u_env.decay); end
      end
      if (k == 46 || k == 52) begin
        vectors++; if (dut.u_env.decay !== 4'd0) begin miscompares++; $display("FAIL env_floor q%0d got %0d want 0", k, dut.u_env.decay); end
      end
      if (k == 55) begin
        vectors++; if (dut.u_env.decay !== 4'd15) begin miscompares++; $display("FAIL env_loop got %0d want 15", dut.u_env.decay); end
      end
    end
    // Load and qframe together: restart is deferred to the next qframe.
    qframe = 1'b1; wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h00;
    tick;
    qframe = 1'b0; wr_en = 1'b0;
    env_model(1'b1, 1'b1, 4'd2, 1'b1);
    vectors++; if (dut.u_env.decay !== 4'd14) begin miscompares++; $display("FAIL env_same_cycle got %0d want 14", dut.u_env.decay); end
    qframe = 1'b1;
    tick;
    qframe = 1'b0;
    env_model(1'b1, 1'b0, 4'd2, 1'b1);
    vectors++; if (dut.u_env.decay !== m_decay || m_decay != 4'd15) begin miscompares++; $display("FAIL env_deferred_start got %0d want 15", dut.u_env.decay); end
  endtask

  task automatic test_enable;
    write_reg(2'd3, 8'h08);
    vectors++; if (dut.length !== 8'd254) begin miscompares++; $display("FAIL en_load got %0d want 254", dut.length); end
    len_en = 1'b0;
    tick;
    vectors++; if (dut.length !== 8'd0) begin miscompares++; $display("FAIL en_clear got %0d want 0", dut.length); end
    vectors++; if (len_active !== 1'b0) begin miscompares++; $display("FAIL en_len_active got %0b want 0", len_active); end
    write_reg(2'd3, 8'h08);
    vectors++; if (dut.length !== 8'd0) begin miscompares++; $display("FAIL en_ignored_load got %0d want 0", dut.length); end
    len_en = 1'b1;
    tick;
  endtask

  task automatic test_reset_mid;
    bit found;
    write_reg(2'd0, 8'h3F);
    write_reg(2'd2, 8'h00);
    write_reg(2'd3, 8'h08);
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      timer_ce = 1'b1;
      tick;
      if (dac == 4'd15) found = 1;
    end
    timer_ce = 1'b0;
    vectors++; if (!found) begin miscompares++; $display("FAIL rm_wait_dac15 got timeout want dac 15"); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (dac !== 4'd0) begin miscompares++; $display("FAIL rm_dac got %0d want 0", dac); end
    vectors++; if (len_active !== 1'b0) begin miscompares++; $display("FAIL rm_len_active got %0b want 0", len_active); end
    vectors++; if (dut.lfsr !== 15'h0001) begin miscompares++; $display("FAIL rm_lfsr got %h want 0001", dut.lfsr); end
    tick;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    vectors++; if (dut.lfsr !== 15'h0001) begin miscompares++; $display("FAIL rm_lfsr_release got %h want 0001", dut.lfsr); end
    timer_ce = 1'b1;
    tick;
    timer_ce = 1'b0;
    vectors++; if (dut.lfsr !== 15'h4000) begin miscompares++; $display("FAIL rm_first_step got %h want 4000", dut.lfsr); end
  endtask

  initial begin
    test_reset;
    test_const_volume;
    test_lfsr_scoreboard;
    test_length;
    test_envelope;
    test_enable;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
